// File: rtl/btn_evt_pkg.sv
// Shared constants and slot helpers for the push-button event scheduler.
// A slot index packs {button id, event type}: the LSB is the type and the upper bits are the button.
package btn_evt_pkg;

  localparam int ID_W = 3;

  typedef enum logic {
    EVT_SHORT = 1'b0,
    EVT_LONG  = 1'b1
  } evt_type_e;

  function automatic logic [ID_W-1:0] slot_id(input int slot);
    return ID_W'(slot >> 1);
  endfunction

  function automatic logic slot_is_long(input int slot);
    return slot[0];
  endfunction

  function automatic int slot_of(input logic [ID_W-1:0] id, input evt_type_e kind);
    return int'({id, kind});
  endfunction

endpackage

// File: rtl/btn_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after ptr, wrapping around.
module btn_rr_arbiter #(
  parameter int N_REQ = 8,
  parameter int IDX_W = 3
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = IDX_W'((int'(ptr) + off) % N_REQ);
      if (!gnt_valid && req[idx]) begin
        gnt[idx]  = 1'b1;
        gnt_idx   = idx;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_event_scheduler.sv
// Push-button front end: paces the debouncers, classifies presses as SHORT/LONG,
// and serialises pending events round-robin onto one valid/ready port.
module button_event_scheduler
  import btn_evt_pkg::*;
#(
  parameter int N_BTN      = 4,
  parameter int TICK_DIV   = 100000,
  parameter int LONG_TICKS = 500,
  parameter int CNT_W      = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             sample_tick,
  input  logic [N_BTN-1:0] pb_debounced,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_id,
  output logic             evt_long,
  output logic             evt_overrun
);

  localparam int N_SLOT = 2 * N_BTN;
  localparam int IDX_W  = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;
  localparam int DIV_W  = $clog2(TICK_DIV);

  logic [DIV_W-1:0]  div_cnt;
  logic [N_BTN-1:0]  prev;
  logic [N_SLOT-1:0] set_vec;
  logic [N_SLOT-1:0] pend;
  logic [N_SLOT-1:0] gnt;
  logic [N_SLOT-1:0] taken;
  logic [N_SLOT-1:0] overrun_vec;
  logic [IDX_W-1:0]  gnt_idx;
  logic [IDX_W-1:0]  rr_ptr;
  logic              gnt_valid;
  logic              out_free;
  logic              load;

  assign sample_tick = (div_cnt == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (sample_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev <= '0;
    end else begin
      prev <= pb_debounced;
    end
  end

  // A press reaching LONG_TICKS held ticks emits LONG once; an earlier release emits SHORT.
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic [CNT_W-1:0] hold_cnt;
    logic             long_done;
    logic             rise;
    logic             held;
    logic             fall;
    logic             fire_long;

    assign rise      = pb_debounced[i] & ~prev[i];
    assign held      = pb_debounced[i] & prev[i];
    assign fall      = ~pb_debounced[i] & prev[i];
    assign fire_long = held & sample_tick & ~long_done & (hold_cnt == CNT_W'(LONG_TICKS - 1));

    assign set_vec[2*i]   = fall & ~long_done;
    assign set_vec[2*i+1] = fire_long;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        hold_cnt  <= '0;
        long_done <= 1'b0;
      end else if (rise) begin
        hold_cnt  <= '0;
        long_done <= 1'b0;
      end else if (held) begin
        if (sample_tick && (hold_cnt != '1)) begin
          hold_cnt <= hold_cnt + CNT_W'(1);
        end
        if (fire_long) begin
          long_done <= 1'b1;
        end
      end else if (fall) begin
        hold_cnt <= '0;
      end
    end
  end

  btn_rr_arbiter #(
    .N_REQ (N_SLOT),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (pend),
    .ptr       (rr_ptr),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign out_free    = ~evt_valid | evt_ready;
  assign load        = out_free & gnt_valid;
  assign taken       = gnt & {N_SLOT{load}};
  // A new event on a slot being granted this cycle is kept, not counted as overrun.
  assign overrun_vec = set_vec & pend & ~taken;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend        <= '0;
      evt_overrun <= 1'b0;
    end else begin
      pend        <= (pend & ~taken) | set_vec;
      evt_overrun <= |overrun_vec;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_long  <= 1'b0;
      rr_ptr    <= '0;
    end else if (load) begin
      evt_valid <= 1'b1;
      evt_id    <= slot_id(int'(gnt_idx));
      evt_long  <= slot_is_long(int'(gnt_idx));
      rr_ptr    <= (gnt_idx == IDX_W'(N_SLOT - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end else if (out_free) begin
      evt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_button_event_scheduler.sv
// Self-checking bench: event-level reference model compared every cycle, plus directed scenarios.
module tb_button_event_scheduler;

  localparam int N_BTN      = 4;
  localparam int TICK_DIV   = 4;
  localparam int LONG_TICKS = 5;
  localparam int N_SLOT     = 2 * N_BTN;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sample_tick;
  logic [N_BTN-1:0] pb = '0;
  logic             evt_valid;
  logic             evt_ready = 1'b0;
  logic [2:0]       evt_id;
  logic             evt_long;
  logic             evt_overrun;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  button_event_scheduler #(
    .N_BTN      (N_BTN),
    .TICK_DIV   (TICK_DIV),
    .LONG_TICKS (LONG_TICKS),
    .CNT_W      (10)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_tick  (sample_tick),
    .pb_debounced (pb),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_id       (evt_id),
    .evt_long     (evt_long),
    .evt_overrun  (evt_overrun)
  );

  // Reference model state: ticks held per press, pending slots, presented event.
  int m_div;
  int m_held [N_BTN];
  bit m_prev [N_BTN];
  bit m_pend [N_SLOT];
  int m_ptr;
  bit m_valid;
  int m_id;
  bit m_long;
  bit m_ovr;

  int log_id [$];
  bit log_long [$];
  bit [N_BTN-1:0] log_pb [$];
  int valid_cycles = 0;
  int ovr_cnt = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit tick;
    bit raise [N_SLOT];
    bit any_ovr;
    int k;
    if (!rst_n) begin
      m_div = 0;
      foreach (m_held[b]) begin
        m_held[b] = 0;
        m_prev[b] = 1'b0;
      end
      foreach (m_pend[s]) m_pend[s] = 1'b0;
      m_ptr   = 0;
      m_valid = 1'b0;
      m_id    = 0;
      m_long  = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      tick  = (m_div == TICK_DIV - 1);
      m_div = (m_div + 1) % TICK_DIV;
      foreach (raise[s]) raise[s] = 1'b0;
      for (int b = 0; b < N_BTN; b++) begin
        if (pb[b] && !m_prev[b]) begin
          m_held[b] = 0;
        end else if (pb[b] && tick) begin
          m_held[b]++;
          if (m_held[b] == LONG_TICKS) raise[2*b+1] = 1'b1;
        end else if (!pb[b] && m_prev[b]) begin
          if (m_held[b] < LONG_TICKS) raise[2*b] = 1'b1;
        end
        m_prev[b] = pb[b];
      end
      if (!m_valid || evt_ready) begin
        m_valid = 1'b0;
        for (int s = 0; s < N_SLOT; s++) begin
          k = (m_ptr + s) % N_SLOT;
          if (m_pend[k]) begin
            m_valid   = 1'b1;
            m_id      = k / 2;
            m_long    = (k % 2) == 1;
            m_pend[k] = 1'b0;
            m_ptr     = (k + 1) % N_SLOT;
            break;
          end
        end
      end
      any_ovr = 1'b0;
      for (int s = 0; s < N_SLOT; s++) begin
        if (raise[s]) begin
          if (m_pend[s]) any_ovr = 1'b1;
          m_pend[s] = 1'b1;
        end
      end
      m_ovr = any_ovr;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_output("sample_tick", 32'(sample_tick), 32'(m_div == TICK_DIV - 1));
      check_output("evt_valid", 32'(evt_valid), 32'(m_valid));
      check_output("evt_id", 32'(evt_id), 32'(m_id));
      check_output("evt_long", 32'(evt_long), 32'(m_long));
      check_output("evt_overrun", 32'(evt_overrun), 32'(m_ovr));
      if (evt_valid) valid_cycles++;
      if (evt_overrun) ovr_cnt++;
      if (evt_valid && evt_ready) begin
        log_id.push_back(int'(evt_id));
        log_long.push_back(evt_long);
        log_pb.push_back(pb);
      end
    end
  end

  task automatic apply_stimulus(input logic [N_BTN-1:0] p, input logic rdy, input int cycles);
    pb = p;
    evt_ready = rdy;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    apply_stimulus('0, 1'b0, 2);
    rst_n = 1'b1;
  endtask

  initial begin
    int n0;
    int vc0;
    int ov0;
    int first_tick;

    rst_n = 1'b0;
    pb = '1;
    evt_ready = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk_en = 1'b1;
    check_output("rst_valid", 32'(evt_valid), 32'd0);
    check_output("rst_id", 32'(evt_id), 32'd0);
    check_output("rst_long", 32'(evt_long), 32'd0);
    check_output("rst_overrun", 32'(evt_overrun), 32'd0);
    check_output("rst_tick", 32'(sample_tick), 32'd0);

    $display("[TB] reset release and first tick");
    rst_n = 1'b1;
    pb = '0;
    first_tick = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (sample_tick && first_tick == 0) first_tick = c;
    end
    check_output("first_tick_cycle", 32'(first_tick), 32'd4);
    @(posedge clk);
    #1;

    $display("[TB] short press on button 2");
    n0 = log_id.size();
    vc0 = valid_cycles;
    apply_stimulus(4'b0100, 1'b1, 12);
    apply_stimulus(4'b0000, 1'b1, 8);
    check_output("short_count", 32'(log_id.size() - n0), 32'd1);
    if (log_id.size() > n0) begin
      check_output("short_id", 32'(log_id[n0]), 32'd2);
      check_output("short_long", 32'(log_long[n0]), 32'd0);
    end
    check_output("short_valid_cycles", 32'(valid_cycles - vc0), 32'd1);

    $display("[TB] long press on button 1");
    n0 = log_id.size();
    apply_stimulus(4'b0010, 1'b1, 48);
    check_output("long_count", 32'(log_id.size() - n0), 32'd1);
    if (log_id.size() > n0) begin
      check_output("long_id", 32'(log_id[n0]), 32'd1);
      check_output("long_long", 32'(log_long[n0]), 32'd1);
      check_output("long_while_held", 32'(log_pb[n0][1]), 32'd1);
    end
    apply_stimulus(4'b0000, 1'b1, 12);
    check_output("long_no_short", 32'(log_id.size() - n0), 32'd1);

    $display("[TB] contention on buttons 0,1,3");
    reset_dut();
    n0 = log_id.size();
    apply_stimulus(4'b1011, 1'b0, 6);
    apply_stimulus(4'b0000, 1'b0, 10);
    check_output("stall_valid", 32'(evt_valid), 32'd1);
    check_output("stall_id", 32'(evt_id), 32'd0);
    apply_stimulus(4'b0000, 1'b1, 6);
    check_output("cont_count", 32'(log_id.size() - n0), 32'd3);
    if (log_id.size() >= n0 + 3) begin
      check_output("cont_id0", 32'(log_id[n0]), 32'd0);
      check_output("cont_id1", 32'(log_id[n0+1]), 32'd1);
      check_output("cont_id2", 32'(log_id[n0+2]), 32'd3);
      check_output("cont_long", 32'(log_long[n0] | log_long[n0+1] | log_long[n0+2]), 32'd0);
    end

    $display("[TB] overrun on button 0");
    n0 = log_id.size();
    ov0 = ovr_cnt;
    apply_stimulus(4'b1000, 1'b0, 6);
    apply_stimulus(4'b0000, 1'b0, 4);
    apply_stimulus(4'b0001, 1'b0, 6);
    apply_stimulus(4'b0000, 1'b0, 4);
    apply_stimulus(4'b0001, 1'b0, 6);
    apply_stimulus(4'b0000, 1'b0, 4);
    check_output("ovr_pulses", 32'(ovr_cnt - ov0), 32'd1);
    apply_stimulus(4'b0000, 1'b1, 8);
    check_output("ovr_count", 32'(log_id.size() - n0), 32'd2);
    if (log_id.size() >= n0 + 2) begin
      check_output("ovr_first_id", 32'(log_id[n0]), 32'd3);
      check_output("ovr_second_id", 32'(log_id[n0+1]), 32'd0);
    end

    $display("[TB] reset while events are pending");
    apply_stimulus(4'b1110, 1'b0, 6);
    apply_stimulus(4'b0000, 1'b0, 4);
    check_output("pre_reset_valid", 32'(evt_valid), 32'd1);
    reset_dut();
    n0 = log_id.size();
    apply_stimulus(4'b0000, 1'b1, 20);
    check_output("post_reset_none", 32'(log_id.size() - n0), 32'd0);
    check_output("post_reset_valid", 32'(evt_valid), 32'd0);
    apply_stimulus(4'b0100, 1'b1, 6);
    apply_stimulus(4'b0000, 1'b1, 6);
    check_output("post_reset_new", 32'(log_id.size() - n0), 32'd1);
    if (log_id.size() > n0) check_output("post_reset_id", 32'(log_id[n0]), 32'd2);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
